// File: rtl/spi_arbiter.sv
// Round-robin arbiter granting one read requester and one write requester access to a single SPI master.
// Optional WAIT watchdog is compiled in with `define SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
  parameter int DATA_W         = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_ack,
  output logic              wr_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              rd,
  output logic              wr,
  output logic [DATA_W-1:0] spi_wdata,
  input  logic [DATA_W-1:0] spi_rdata,
  input  logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // gap_cnt counts clocks since the ack edge, so leaving GAP at GAP_CYCLES-1
  // lets the next grant land exactly GAP_CYCLES clocks after the ack.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LIM = (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_e            state_q, state_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              rd_ack_q, rd_ack_d;
  logic              wr_ack_q, wr_ack_d;
  logic              err_q, err_d;
  logic              done_d_q;
  logic              last_wr_q, last_wr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] spi_wdata_q, spi_wdata_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              done_rise;
  logic              timeout;
  logic              grant_rd;
  logic              grant_wr;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt_q <= '0;
    else      wait_cnt_q <= wait_cnt_d;
  end

  always_comb begin
    wait_cnt_d = '0;
    if (state_q == ST_WAIT && !done_rise) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  assign timeout = (state_q == ST_WAIT) && (wait_cnt_q == TO_LIM);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign done_rise = done & ~done_d_q;
  // Round-robin: on a tie, grant whichever side did not win last time.
  assign grant_rd  = rd_req & (~wr_req | last_wr_q);
  assign grant_wr  = wr_req & (~rd_req | ~last_wr_q);

  // NOTE: every output of this block is assigned a default first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    rd_ack_d    = 1'b0;
    wr_ack_d    = 1'b0;
    err_d       = 1'b0;
    last_wr_d   = last_wr_q;
    rd_data_d   = rd_data_q;
    spi_wdata_d = spi_wdata_q;
    gap_cnt_d   = gap_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_rd) begin
          rd_d      = 1'b1;
          last_wr_d = 1'b0;
          state_d   = ST_WAIT;
        end else if (grant_wr) begin
          wr_d        = 1'b1;
          spi_wdata_d = wr_data;
          last_wr_d   = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done_rise || timeout) begin
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          rd_ack_d  = rd_q;
          wr_ack_d  = wr_q;
          err_d     = ~done_rise;
          gap_cnt_d = GAP_W'(1);
          state_d   = ST_GAP;
          if (done_rise && rd_q) rd_data_d = spi_rdata;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q >= GAP_LIM) begin
          if (!done) state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the async reset drops rd/wr without waiting for clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_ack_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      done_d_q    <= 1'b0;
      last_wr_q   <= 1'b1;
      rd_data_q   <= '0;
      spi_wdata_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rd_ack_q    <= rd_ack_d;
      wr_ack_q    <= wr_ack_d;
      err_q       <= err_d;
      done_d_q    <= done;
      last_wr_q   <= last_wr_d;
      rd_data_q   <= rd_data_d;
      spi_wdata_q <= spi_wdata_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign rd        = rd_q;
  assign wr        = wr_q;
  assign rd_ack    = rd_ack_q;
  assign wr_ack    = wr_ack_q;
  assign rd_data   = rd_data_q;
  assign spi_wdata = spi_wdata_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef SPI_ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
  assign err       = 1'b0;
`endif

endmodule
